// File: rtl/instr_queue_multi_issue.sv
// Fetch-to-decode queue: IPF round-robin banks,
// up to ISSUE_WIDTH in-order lanes out, replay on overflow.
module instr_queue_multi_issue #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned ISSUE_WIDTH     = 2,
  parameter int unsigned ADDR_WIDTH      = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [INSTR_PER_FETCH*32-1:0]        instr_i,
  input  logic [INSTR_PER_FETCH*ADDR_WIDTH-1:0] addr_i,
  input  logic [INSTR_PER_FETCH-1:0]           valid_i,
  input  logic [INSTR_PER_FETCH-1:0]           taken_i,
  input  logic [ADDR_WIDTH-1:0]                predict_address_i,
  input  logic                                 ex_valid_i,
  output logic                                 ready_o,
  output logic [INSTR_PER_FETCH-1:0]           consumed_o,
  output logic                                 replay_o,
  output logic [ADDR_WIDTH-1:0]                replay_addr_o,
  output logic [ISSUE_WIDTH*32-1:0]            fetch_instr_o,
  output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]    fetch_addr_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_taken_o,
  output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]    fetch_predict_addr_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_ex_o,
  output logic [ISSUE_WIDTH-1:0]               fetch_valid_o,
  input  logic [ISSUE_WIDTH-1:0]               fetch_ready_i,
  output logic [$clog2(INSTR_PER_FETCH*FIFO_DEPTH+1)-1:0] usage_o
);

  localparam int unsigned IPF = INSTR_PER_FETCH;
  localparam int unsigned IW  = ISSUE_WIDTH;
  localparam int unsigned AW  = ADDR_WIDTH;
  localparam int unsigned PW  = $clog2(IPF);
  localparam int unsigned DW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned UW  = $clog2(IPF*FIFO_DEPTH+1);
  localparam int unsigned NW  = $clog2(IPF+1);

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          taken;
    logic [AW-1:0] pred;
    logic          ex;
  } entry_t;

  entry_t        mem_q  [IPF][FIFO_DEPTH];
  logic [DW-1:0] wptr_q [IPF];
  logic [DW-1:0] rptr_q [IPF];
  logic [CW-1:0] cnt_q  [IPF];

  logic [PW-1:0] idx_is_q, idx_is_d;
  logic [PW-1:0] idx_ds_q, idx_ds_d;
  logic [UW-1:0] usage_q, usage_d;

  logic           clr;
  logic [IPF-1:0] full;
  logic [IPF-1:0] want;
  logic [IPF-1:0] stored;
  logic [IPF-1:0] miss;
  logic [PW-1:0]  slot_bank [IPF];
  logic [NW-1:0]  n_store;
  logic [IPF-1:0] push;
  entry_t         push_e [IPF];
  logic [IPF-1:0] pop;
  logic [PW-1:0]  lane_bank [IW];
  entry_t         lane_e [IW];
  logic [IW-1:0]  lvalid;
  logic [NW-1:0]  n_pop;

  assign clr = rst_i | flush_i;

  // bank full flags and global ready
  always_comb begin
    full = '0;
    for (int b = 0; b < IPF; b++)
      full[b] = (cnt_q[b] == CW'(FIFO_DEPTH));
  end

  assign ready_o = ~|full;

  // truncate after first taken, map to banks, store strict prefix
  always_comb begin
    logic [PW-1:0] rank;
    logic          ok;
    logic          seen;
    want    = '0;
    stored  = '0;
    n_store = '0;
    rank    = '0;
    ok      = ~clr;
    seen    = 1'b0;
    for (int i = 0; i < IPF; i++) begin
      slot_bank[i] = idx_is_q + rank;
      want[i]      = valid_i[i] & ~seen;
      seen         = seen | taken_i[i];
      if (want[i]) begin
        ok        = ok & ~full[slot_bank[i]];
        stored[i] = ok;
        rank      = rank + 1'b1;
      end
      n_store = n_store + NW'(stored[i]);
    end
  end

  assign miss       = want & ~stored;
  assign replay_o   = (|miss) & ~clr;
  assign consumed_o = stored;

  // address of the lowest slot that was wanted but dropped
  always_comb begin
    replay_addr_o = '0;
    if (!clr) begin
      for (int i = IPF-1; i >= 0; i--)
        if (miss[i]) replay_addr_o = addr_i[i*AW +: AW];
    end
  end

  // route each stored slot to its bank
  always_comb begin
    for (int b = 0; b < IPF; b++) begin
      push[b]   = 1'b0;
      push_e[b] = '0;
      for (int i = 0; i < IPF; i++) begin
        if (stored[i] && slot_bank[i] == PW'(b)) begin
          push[b]         = 1'b1;
          push_e[b].instr = instr_i[i*32 +: 32];
          push_e[b].addr  = addr_i[i*AW +: AW];
          push_e[b].taken = taken_i[i];
          push_e[b].pred  = taken_i[i] ? predict_address_i : '0;
          push_e[b].ex    = ex_valid_i;
        end
      end
    end
  end

  // lane view, thermometer valid cut after an exception, prefix pop
  always_comb begin
    logic chain;
    logic go;
    chain = 1'b1;
    go    = ~clr;
    n_pop = '0;
    pop   = '0;
    for (int k = 0; k < IW; k++) begin
      lane_bank[k] = idx_ds_q + PW'(k);
      lane_e[k]    = mem_q[lane_bank[k]][rptr_q[lane_bank[k]]];
      lvalid[k]    = (cnt_q[lane_bank[k]] != '0) & chain;
      chain        = lvalid[k] & ~lane_e[k].ex;
      go           = go & lvalid[k] & fetch_ready_i[k];
      if (go) begin
        n_pop             = n_pop + 1'b1;
        pop[lane_bank[k]] = 1'b1;
      end
    end
  end

  // lane output packing
  always_comb begin
    for (int k = 0; k < IW; k++) begin
      fetch_instr_o[k*32 +: 32]        = lane_e[k].instr;
      fetch_addr_o[k*AW +: AW]         = lane_e[k].addr;
      fetch_taken_o[k]                 = lane_e[k].taken;
      fetch_predict_addr_o[k*AW +: AW] = lane_e[k].pred;
      fetch_ex_o[k]                    = lane_e[k].ex;
    end
  end

  assign fetch_valid_o = lvalid;
  assign usage_o       = usage_q;
  assign idx_is_d      = idx_is_q + PW'(n_store);
  assign idx_ds_d      = idx_ds_q + PW'(n_pop);
  assign usage_d       = usage_q + UW'(n_store) - UW'(n_pop);

  // pointers and occupancy; reset and flush both clear
  always_ff @(posedge clk_i) begin
    if (clr) begin
      idx_is_q <= '0;
      idx_ds_q <= '0;
      usage_q  <= '0;
      for (int b = 0; b < IPF; b++) begin
        wptr_q[b] <= '0;
        rptr_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      idx_is_q <= idx_is_d;
      idx_ds_q <= idx_ds_d;
      usage_q  <= usage_d;
      for (int b = 0; b < IPF; b++) begin
        if (push[b]) wptr_q[b] <= wptr_q[b] + 1'b1;
        if (pop[b])  rptr_q[b] <= rptr_q[b] + 1'b1;
        cnt_q[b] <= cnt_q[b] + CW'(push[b]) - CW'(pop[b]);
      end
    end
  end

  // bank storage, written only on push
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < IPF; b++)
      if (push[b]) mem_q[b][wptr_q[b]] <= push_e[b];
  end

endmodule
